cfg_regbank: RTL and testbench

Parametrised configuration register bank on the FX bus; the successor of the fixed-size configuration register inside the control top. It decodes device ID and register index from the 22-bit FX address and holds NREG registers of DW bits as a shadow/active pair. A commit write transfers every shadow register to the active outputs in one cycle. It also provides broadcast writes, registered read-back and a commit counter.

---
 rtl/cfg_regbank_if.sv | 32 +++
 rtl/cfg_regbank.sv | 124 ++++++++++++
 tb/tb_cfg_regbank.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_regbank_if.sv
// FX configuration bus: write port, read port and registered read data.
// The master drives strobes, addresses and write data; the slave returns fx_q.
interface cfg_regbank_if #(
  parameter int unsigned DW = 8
);

  logic          fx_wr;
  logic [21:0]   fx_waddr;
  logic [DW-1:0] fx_data;
  logic          fx_rd;
  logic [21:0]   fx_raddr;
  logic [DW-1:0] fx_q;

  modport master (
    output fx_wr,
    output fx_waddr,
    output fx_data,
    output fx_rd,
    output fx_raddr,
    input  fx_q
  );

  modport slave (
    input  fx_wr,
    input  fx_waddr,
    input  fx_data,
    input  fx_rd,
    input  fx_raddr,
    output fx_q
  );

endinterface

// File: rtl/cfg_regbank.sv
// Configuration register bank on the FX bus.
// NREG registers of DW bits are held as a shadow/active pair. Writes land in the
// shadow copy; a commit write copies every shadow register to the active copy in
// one cycle. Active registers drive cfg_bus. Reads are registered (1-cycle
// latency) and return zero when this device is not addressed so that fx_q of
// several devices can be OR-combined.
module cfg_regbank #(
  parameter int unsigned        DW       = 8,
  parameter int unsigned        NREG     = 16,
  parameter logic [NREG*DW-1:0] RST_VAL  = '0,
  parameter logic [5:0]         BCAST_ID = 6'h3F
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [5:0]           dev_id,
  cfg_regbank_if.slave         fx,
  output logic [NREG*DW-1:0]   cfg_bus,
  output logic                 cfg_upd,
  output logic [7:0]           commit_cnt
);

  localparam int unsigned IdxW = (NREG > 1) ? $clog2(NREG) : 1;
  // Commit counter widened so it can be truncated or zero-extended to DW.
  localparam int unsigned CntW = (DW > 8) ? DW : 8;

  localparam logic [15:0] CommitIdx = 16'hFFFF;
  localparam logic [14:0] CntIdx    = 15'h7FFE;

  logic [DW-1:0] shadow_q [NREG];
  logic [DW-1:0] shadow_d [NREG];
  logic [DW-1:0] active_q [NREG];
  logic [DW-1:0] active_d [NREG];
  logic [7:0]    cnt_q, cnt_d;
  logic          upd_q, upd_d;
  logic [DW-1:0] fx_q_q, fx_q_d;

  logic            wr_hit, wr_reg, wr_commit;
  logic            rd_hit, rd_reg, rd_cnt;
  logic [IdxW-1:0] widx, ridx;
  logic [CntW-1:0] cnt_ext;
  logic [DW-1:0]   rdata;

  // Write decode: own ID or broadcast; index 16'hFFFE and other out-of-range
  // indices fall through both selects and are ignored.
  always_comb begin
    wr_hit    = fx.fx_wr && ((fx.fx_waddr[21:16] == dev_id) ||
                             (fx.fx_waddr[21:16] == BCAST_ID));
    wr_reg    = wr_hit && (32'(fx.fx_waddr[15:0]) < NREG);
    wr_commit = wr_hit && (fx.fx_waddr[15:0] == CommitIdx);
    widx      = fx.fx_waddr[IdxW-1:0];
  end

  // Read decode: exact ID match only, broadcast ID never answers a read.
  always_comb begin
    rd_hit = fx.fx_rd && (fx.fx_raddr[21:16] == dev_id);
    rd_reg = 32'(fx.fx_raddr[14:0]) < NREG;
    rd_cnt = fx.fx_raddr[14:0] == CntIdx;
    ridx   = fx.fx_raddr[IdxW-1:0];
  end

  assign cnt_ext = CntW'(cnt_q);

  // Read data mux from current (pre-edge) state, so same-cycle writes and
  // commits are not visible to the read.
  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      if (rd_reg) begin
        rdata = fx.fx_raddr[15] ? shadow_q[ridx] : active_q[ridx];
      end else if (rd_cnt) begin
        rdata = cnt_ext[DW-1:0];
      end
    end
  end

  // Next-state for shadow/active copies, commit counter, pulse and read data.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    upd_d    = 1'b0;
    fx_q_d   = fx_q_q;
    if (wr_reg) begin
      shadow_d[widx] = fx.fx_data;
    end
    if (wr_commit) begin
      active_d = shadow_q;
      cnt_d    = cnt_q + 8'd1;
      upd_d    = 1'b1;
    end
    // fx_q reloads on every read strobe, with zero if not addressed.
    if (fx.fx_rd) begin
      fx_q_d = rdata;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= RST_VAL[i*DW +: DW];
        active_q[i] <= RST_VAL[i*DW +: DW];
      end
      cnt_q  <= '0;
      upd_q  <= 1'b0;
      fx_q_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
      fx_q_q   <= fx_q_d;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_cfg_bus
    assign cfg_bus[g*DW +: DW] = active_q[g];
  end

  assign cfg_upd    = upd_q;
  assign commit_cnt = cnt_q;
  assign fx.fx_q    = fx_q_q;

endmodule

// File: tb/tb_cfg_regbank.sv
// Bench for cfg_regbank: directed scenarios plus randomized traffic, with a
// behavioural model and a read-data scoreboard checked by a separate monitor.
module tb_cfg_regbank;

  localparam int unsigned        DW       = 8;
  localparam int unsigned        NREG     = 16;
  localparam logic [NREG*DW-1:0] RST_VAL  = {{((NREG-1)*DW){1'b0}}, 8'h5A};
  localparam logic [5:0]         DEV      = 6'h03;

  logic              clk_sys = 1'b0;
  logic              rst_n;
  logic [5:0]        dev_id;
  logic [NREG*DW-1:0] cfg_bus;
  logic              cfg_upd;
  logic [7:0]        commit_cnt;

  always #5 clk_sys = ~clk_sys;

  cfg_regbank_if #(.DW(DW)) bus ();

  cfg_regbank #(
    .DW       (DW),
    .NREG     (NREG),
    .RST_VAL  (RST_VAL),
    .BCAST_ID (6'h3F)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .dev_id     (dev_id),
    .fx         (bus),
    .cfg_bus    (cfg_bus),
    .cfg_upd    (cfg_upd),
    .commit_cnt (commit_cnt)
  );

  // Reference model state (what the DUT should hold after the last edge).
  logic [7:0] m_shadow [NREG];
  logic [7:0] m_active [NREG];
  int         m_cnt;
  logic       m_upd;
  logic [7:0] m_q;
  logic       pop_due;
  logic [7:0] exp_q [$];
  bit         mon_en;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_shadow[i] = RST_VAL[i*DW +: DW];
      m_active[i] = RST_VAL[i*DW +: DW];
    end
    m_cnt   = 0;
    m_upd   = 1'b0;
    m_q     = 8'h00;
    pop_due = 1'b0;
    exp_q.delete();
  endfunction

  function automatic logic [127:0] model_bus();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[i*8 +: 8] = m_active[i];
    return v;
  endfunction

  function automatic logic [7:0] model_read(input logic [21:0] ra);
    int idx;
    if (ra[21:16] != DEV) return 8'h00;
    idx = int'(ra[14:0]);
    if (idx < NREG) return ra[15] ? m_shadow[idx] : m_active[idx];
    if (idx == 32'h7FFE) return m_cnt[7:0];
    return 8'h00;
  endfunction

  function automatic void model_write(input logic wr, input logic [21:0] wa, input logic [7:0] wd);
    int idx;
    m_upd = 1'b0;
    if (!wr) return;
    if (wa[21:16] != DEV && wa[21:16] != 6'h3F) return;
    idx = int'(wa[15:0]);
    if (idx < NREG) begin
      m_shadow[idx] = wd;
    end else if (idx == 32'hFFFF) begin
      for (int i = 0; i < NREG; i++) m_active[i] = m_shadow[i];
      m_cnt = (m_cnt + 1) % 256;
      m_upd = 1'b1;
    end
  endfunction

  // One bus cycle: drive, queue expected read data, clock, update model.
  task automatic cycle(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                       input logic rd, input logic [21:0] ra);
    bus.fx_wr    = wr;
    bus.fx_waddr = wa;
    bus.fx_data  = wd;
    bus.fx_rd    = rd;
    bus.fx_raddr = ra;
    if (rd) exp_q.push_back(model_read(ra));
    @(posedge clk_sys);
    #1;
    model_write(wr, wa, wd);
    pop_due      = rd;
    bus.fx_wr    = 1'b0;
    bus.fx_rd    = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 22'h0, 8'h00, 1'b0, 22'h0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.fx_wr = 1'b0;
    bus.fx_rd = 1'b0;
    @(posedge clk_sys);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard when read data is due and checks all outputs.
  always @(negedge clk_sys) begin
    if (mon_en) begin
      if (pop_due) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: got empty queue expected an entry");
        end else begin
          m_q = exp_q.pop_front();
        end
        pop_due = 1'b0;
      end
      check("mon_fx_q", 128'(bus.fx_q), 128'(m_q));
      check("mon_cfg_bus", 128'(cfg_bus), model_bus());
      check("mon_cfg_upd", 128'(cfg_upd), 128'(m_upd));
      check("mon_commit_cnt", 128'(commit_cnt), 128'(m_cnt[7:0]));
    end
  end

  initial begin
    mon_en       = 1'b0;
    rst_n        = 1'b0;
    dev_id       = DEV;
    bus.fx_wr    = 1'b0;
    bus.fx_waddr = '0;
    bus.fx_data  = '0;
    bus.fx_rd    = 1'b0;
    bus.fx_raddr = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    model_reset();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Reset state.
    check("rst_bus0", 128'(cfg_bus[7:0]), 128'(8'h5A));
    check("rst_fx_q", 128'(bus.fx_q), 128'(0));
    check("rst_cnt", 128'(commit_cnt), 128'(0));
    check("rst_upd", 128'(cfg_upd), 128'(0));

    // Shadow write, read back, commit.
    cycle(1'b1, {DEV, 16'h0002}, 8'hA5, 1'b0, 22'h0);
    cycle(1'b0, 22'h0, 8'h00, 1'b1, {DEV, 1'b1, 15'd2});
    check("shadow_rd", 128'(bus.fx_q), 128'(8'hA5));
    cycle(1'b0, 22'h0, 8'h00, 1'b1, {DEV, 1'b0, 15'd2});
    check("active_rd_pre", 128'(bus.fx_q), 128'(0));
    check("bus_pre_commit", 128'(cfg_bus[23:16]), 128'(0));
    cycle(1'b1, {DEV, 16'hFFFF}, 8'h00, 1'b0, 22'h0);
    check("bus_post_commit", 128'(cfg_bus[23:16]), 128'(8'hA5));
    check("upd_pulse", 128'(cfg_upd), 128'(1));
    idle();
    check("upd_drop", 128'(cfg_upd), 128'(0));

    // Broadcast write/commit; broadcast read ignored.
    cycle(1'b1, {6'h3F, 16'h0001}, 8'h77, 1'b0, 22'h0);
    cycle(1'b1, {6'h3F, 16'hFFFF}, 8'h00, 1'b0, 22'h0);
    check("bcast_commit", 128'(cfg_bus[15:8]), 128'(8'h77));
    cycle(1'b0, 22'h0, 8'h00, 1'b1, {6'h3F, 1'b0, 15'd1});
    check("bcast_rd", 128'(bus.fx_q), 128'(0));

    // Foreign device, out-of-range index.
    cycle(1'b1, {6'h04, 16'h0005}, 8'h99, 1'b1, {6'h04, 1'b1, 15'd5});
    check("foreign_rd", 128'(bus.fx_q), 128'(0));
    cycle(1'b1, {DEV, 16'h0020}, 8'hFF, 1'b1, {DEV, 1'b1, 15'd5});
    check("foreign_wr", 128'(bus.fx_q), 128'(0));
    cycle(1'b1, {DEV, 16'hFFFE}, 8'hEE, 1'b1, {DEV, 1'b1, 15'd16});
    check("idx16_rd", 128'(bus.fx_q), 128'(0));

    // Commit counter read and wrap.
    do_reset();
    repeat (3) cycle(1'b1, {DEV, 16'hFFFF}, 8'h00, 1'b0, 22'h0);
    cycle(1'b0, 22'h0, 8'h00, 1'b1, {DEV, 1'b0, 15'h7FFE});
    check("cnt_rd3", 128'(bus.fx_q), 128'(8'h03));
    repeat (253) cycle(1'b1, {DEV, 16'hFFFF}, 8'h00, 1'b0, 22'h0);
    check("cnt_wrap", 128'(commit_cnt), 128'(0));

    // Same-cycle hazards.
    do_reset();
    cycle(1'b1, {DEV, 16'h0000}, 8'h11, 1'b1, {DEV, 1'b0, 15'd0});
    check("wr_rd_active", 128'(bus.fx_q), 128'(8'h5A));
    cycle(1'b1, {DEV, 16'h0000}, 8'h22, 1'b1, {DEV, 1'b1, 15'd0});
    check("wr_rd_shadow", 128'(bus.fx_q), 128'(8'h11));
    cycle(1'b1, {DEV, 16'hFFFF}, 8'h00, 1'b1, {DEV, 1'b0, 15'd0});
    check("commit_rd_active", 128'(bus.fx_q), 128'(8'h5A));
    check("commit_bus0", 128'(cfg_bus[7:0]), 128'(8'h22));
    cycle(1'b1, {DEV, 16'hFFFF}, 8'h00, 1'b1, {DEV, 1'b0, 15'h7FFE});
    check("commit_rd_cnt", 128'(bus.fx_q), 128'(8'h01));
    check("commit_cnt2", 128'(commit_cnt), 128'(2));

    // Reset discards uncommitted shadow writes.
    cycle(1'b1, {DEV, 16'h0003}, 8'h44, 1'b0, 22'h0);
    do_reset();
    check("rst_mid_bus", 128'(cfg_bus), 128'(RST_VAL));
    check("rst_mid_cnt", 128'(commit_cnt), 128'(0));
    cycle(1'b0, 22'h0, 8'h00, 1'b1, {DEV, 1'b1, 15'd3});
    check("rst_mid_shadow", 128'(bus.fx_q), 128'(0));

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [5:0]  wdev, rdev;
      logic [15:0] widx;
      logic [14:0] ridx;
      logic        wr, rd;
      case ($urandom_range(3))
        0:       wdev = DEV;
        1:       wdev = 6'h3F;
        2:       wdev = 6'h04;
        default: wdev = 6'($urandom);
      endcase
      case ($urandom_range(4))
        0, 1:    widx = 16'($urandom_range(NREG - 1));
        2:       widx = 16'hFFFF;
        3:       widx = 16'hFFFE;
        default: widx = 16'($urandom);
      endcase
      case ($urandom_range(3))
        0, 1:    rdev = DEV;
        2:       rdev = 6'h3F;
        default: rdev = 6'($urandom);
      endcase
      case ($urandom_range(3))
        0, 1:    ridx = 15'($urandom_range(NREG - 1));
        2:       ridx = 15'h7FFE;
        default: ridx = 15'($urandom);
      endcase
      wr = ($urandom_range(2) != 0);
      rd = ($urandom_range(1) != 0);
      if ($urandom_range(199) == 0) begin
        do_reset();
      end else begin
        cycle(wr, {wdev, widx}, 8'($urandom), rd, {rdev, 1'($urandom), ridx});
      end
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
